// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 max-pool over sign-magnitude pixels
module maxpool2x2_stream #(
    parameter int N = 32,
    parameter int Q = 16,
    parameter int W = 8,
    parameter int H = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int RW = (H > 1) ? $clog2(H) : 1;
    localparam int LW = ((W / 2) > 1) ? $clog2(W / 2) : 1;

    // Frame geometry must tile exactly into 2x2 windows; Q must fit inside the word.
    if ((W < 2) || (W % 2 != 0) || (H < 2) || (H % 2 != 0) || (Q < 0) || (Q >= N)) begin : g_bad_params
        $error("maxpool2x2_stream: illegal parameter set");
    end

    // Sign-magnitude max: non-negative beats negative (+0 beats -0),
    // larger magnitude wins among positives, smaller among negatives.
    function automatic logic [N-1:0] sm_max(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] r;
        if (a[N-1] != b[N-1]) begin
            r = a[N-1] ? b : a;
        end else if (!a[N-1]) begin
            r = (a[N-2:0] >= b[N-2:0]) ? a : b;
        end else begin
            r = (a[N-2:0] <= b[N-2:0]) ? a : b;
        end
        return r;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [N-1:0]  hreg_q, hreg_d;
    logic          out_valid_q, out_valid_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_last_q, out_last_d;

    logic [N-1:0]  lbuf_q [0:W/2-1];
    logic          lbuf_we;
    logic [LW-1:0] lbuf_idx;
    logic [N-1:0]  hmax;
    logic          accept;
    logic          col_end;
    logic          row_end;

    assign in_ready  = !out_valid_q || out_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

    // Next-state: raster counters, horizontal pair max, line buffer write and result load.
    always_comb begin
        accept      = in_valid && in_ready;
        col_end     = (col_q == CW'(W - 1));
        row_end     = (row_q == RW'(H - 1));
        lbuf_idx    = LW'(col_q >> 1);
        hmax        = sm_max(hreg_q, in_data);
        lbuf_we     = 1'b0;
        col_d       = col_q;
        row_d       = row_q;
        hreg_d      = hreg_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (accept) begin
            if (!col_q[0]) begin
                hreg_d = in_data;
            end else if (!row_q[0]) begin
                lbuf_we = 1'b1;
            end else begin
                out_valid_d = 1'b1;
                out_data_d  = sm_max(hmax, lbuf_q[lbuf_idx]);
                out_last_d  = row_end && col_end;
            end
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Control and output registers; reset drops any partial frame and pending result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q       <= '0;
            row_q       <= '0;
            hreg_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            hreg_q      <= hreg_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    // Line buffer of top-row pair maxima; always written before read, so no reset.
    always_ff @(posedge clk) begin
        if (lbuf_we) begin
            lbuf_q[lbuf_idx] <= hmax;
        end
    end

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// tb/tb_maxpool2x2_stream.sv - directed self-checking bench for maxpool2x2_stream
module tb_maxpool2x2_stream;

    localparam int N = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [N-1:0] in_data = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [N-1:0] out_data;
    logic         out_last;

    int tests_run = 0;
    int tests_failed = 0;

    logic [N-1:0] frame [16];
    logic [N-1:0] got_data[$];
    logic         got_last[$];

    maxpool2x2_stream #(.N(N), .Q(16), .W(4), .H(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    always #5 clk = ~clk;

    // Capture each output beat that will transfer on the coming rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
        end
    end

    // Present n pixels from frame[] (wrapping), holding each until accepted.
    task automatic send_pixels(input int n, output int cycles, output bit timed_out);
        bit acc;
        int wait_c;
        cycles = 0;
        timed_out = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = frame[i % 16];
            wait_c = 0;
            do begin
                @(negedge clk);
                acc = in_ready;
                @(posedge clk);
                #1;
                cycles++;
                wait_c++;
            end while (!acc && wait_c < 50);
            if (!acc) timed_out = 1'b1;
        end
        in_valid = 1'b0;
        in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int k = 0; k < 16; k++) frame[k] = 32'(k) << 16;
    endtask

    task automatic test_reset();
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_data !== 32'h0) begin tests_failed++; $display("FAIL reset_out_data got %h want 0", out_data); end
        tests_run++;
        if (out_last !== 1'b0) begin tests_failed++; $display("FAIL reset_out_last got %b want 0", out_last); end
        tests_run++;
        if (in_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_pos_ramp();
        logic [N-1:0] exp_d [4];
        int c; bit to;
        exp_d = '{32'h0005_0000, 32'h0007_0000, 32'h000D_0000, 32'h000F_0000};
        load_ramp();
        got_data.delete(); got_last.delete();
        send_pixels(16, c, to);
        drain();
        tests_run++;
        if (to) begin tests_failed++; $display("FAIL ramp_timeout got stalled want accepted"); end
        tests_run++;
        if (got_data.size() != 4) begin tests_failed++; $display("FAIL ramp_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i]) begin tests_failed++; $display("FAIL ramp_data[%0d] got %h want %h", i, got_data[i], exp_d[i]); end
            tests_run++;
            if (got_last[i] !== (i == 3)) begin tests_failed++; $display("FAIL ramp_last[%0d] got %b want %b", i, got_last[i], i == 3); end
        end
    endtask

    task automatic test_all_neg();
        logic [N-1:0] exp_d [4];
        int c; bit to;
        exp_d = '{32'h8001_0000, 32'h8003_0000, 32'h8009_0000, 32'h800B_0000};
        for (int k = 0; k < 16; k++) frame[k] = 32'h8000_0000 | (32'(k + 1) << 16);
        got_data.delete(); got_last.delete();
        send_pixels(16, c, to);
        drain();
        tests_run++;
        if (got_data.size() != 4) begin tests_failed++; $display("FAIL neg_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i]) begin tests_failed++; $display("FAIL neg_data[%0d] got %h want %h", i, got_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_mixed();
        logic [N-1:0] exp_d [4];
        int c; bit to;
        // window0 idx 0,1,4,5; window1 idx 2,3,6,7; window2 idx 8,9,12,13; window3 idx 10,11,14,15
        frame = '{32'h8002_0000, 32'h0000_8000, 32'h8000_0000, 32'h8000_0000,
                  32'h8000_4000, 32'h8008_0000, 32'h8000_0000, 32'h0000_0000,
                  32'h8000_0003, 32'h8000_0001, 32'h8000_0000, 32'h8000_0007,
                  32'h8000_0002, 32'h8000_0005, 32'h8000_0000, 32'h8000_FFFF};
        exp_d = '{32'h0000_8000, 32'h0000_0000, 32'h8000_0001, 32'h8000_0000};
        got_data.delete(); got_last.delete();
        send_pixels(16, c, to);
        drain();
        tests_run++;
        if (got_data.size() != 4) begin tests_failed++; $display("FAIL mixed_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i]) begin tests_failed++; $display("FAIL mixed_data[%0d] got %h want %h", i, got_data[i], exp_d[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [N-1:0] exp_d [4];
        int c; bit to;
        int held_bad; int ready_bad; bit bp_to;
        exp_d = '{32'h0005_0000, 32'h0007_0000, 32'h000D_0000, 32'h000F_0000};
        load_ramp();
        got_data.delete(); got_last.delete();
        held_bad = 0; ready_bad = 0; bp_to = 1'b0;
        fork
            send_pixels(16, c, to);
            begin
                int w;
                w = 0;
                while (!out_valid && w < 40) begin
                    @(posedge clk); #1; w++;
                end
                if (!out_valid) bp_to = 1'b1;
                out_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    if (out_valid !== 1'b1 || out_data !== 32'h0005_0000) held_bad++;
                    if (in_ready !== 1'b0) ready_bad++;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        drain();
        tests_run++;
        if (bp_to || to) begin tests_failed++; $display("FAIL bp_timeout got stalled want progress"); end
        tests_run++;
        if (held_bad != 0) begin tests_failed++; $display("FAIL bp_hold got %0d unstable cycles want 0", held_bad); end
        tests_run++;
        if (ready_bad != 0) begin tests_failed++; $display("FAIL bp_in_ready got %0d high cycles want 0", ready_bad); end
        tests_run++;
        if (got_data.size() != 4) begin tests_failed++; $display("FAIL bp_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
                tests_failed++; $display("FAIL bp_data[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_d[i], i == 3);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [N-1:0] exp_d [4];
        int c; bit to;
        exp_d = '{32'h0005_0000, 32'h0007_0000, 32'h000D_0000, 32'h000F_0000};
        load_ramp();
        send_pixels(6, c, to);
        tests_run++;
        if (out_valid !== 1'b1) begin tests_failed++; $display("FAIL mid_pre_valid got %b want 1", out_valid); end
        #1 rst_n = 1'b0;
        #1;
        tests_run++;
        if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_async_valid got %b want 0", out_valid); end
        tests_run++;
        if (out_data !== 32'h0 || in_ready !== 1'b1) begin
            tests_failed++; $display("FAIL mid_async_state got data %h ready %b want 0 1", out_data, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_data.delete(); got_last.delete();
        send_pixels(16, c, to);
        drain();
        tests_run++;
        if (got_data.size() != 4) begin tests_failed++; $display("FAIL mid_count got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 3)) begin
                tests_failed++; $display("FAIL mid_data[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_d[i], i == 3);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_d [4];
        int c; bit to;
        exp_d = '{32'h0005_0000, 32'h0007_0000, 32'h000D_0000, 32'h000F_0000};
        load_ramp();
        got_data.delete(); got_last.delete();
        send_pixels(32, c, to);
        drain();
        tests_run++;
        if (c != 32) begin tests_failed++; $display("FAIL b2b_cycles got %0d want 32", c); end
        tests_run++;
        if (got_data.size() != 8) begin tests_failed++; $display("FAIL b2b_count got %0d want 8", got_data.size()); end
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            tests_run++;
            if (got_data[i] !== exp_d[i % 4] || got_last[i] !== ((i % 4) == 3)) begin
                tests_failed++; $display("FAIL b2b_data[%0d] got %h/%b want %h/%b", i, got_data[i], got_last[i], exp_d[i % 4], (i % 4) == 3);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        test_reset();
        @(posedge clk); #1;
        test_pos_ramp();
        test_all_neg();
        test_mixed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
